// File: rtl/regmax_pkg.sv
// Shared types for the regional-maximum coordinate emitter.
// Optional match counter enabled by REGMAX_EMIT_COUNT_EN.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

package regmax_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } emit_state_t;

   localparam int CNT_WIDTH = $clog2(`CFG_M * `CFG_N + 1);

endpackage

// File: rtl/regmax_coord_emitter.sv
// Scans a snapshot of a regional-maximum bitmap and emits set coordinates.
// REGMAX_EMIT_COUNT_EN adds the match_count output.
module regmax_coord_emitter
   import regmax_pkg::*;
#(
   parameter int M       = `CFG_M,
   parameter int N       = `CFG_N,
   parameter int I_WIDTH = `CFG_I_WIDTH,
   parameter int J_WIDTH = `CFG_J_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [M-1:0][N-1:0]       output_image,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [I_WIDTH-1:0]        out_i,
   output logic [J_WIDTH-1:0]        out_j,
   output logic                      out_last,
   output logic                      done
`ifdef REGMAX_EMIT_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0]      match_count
`endif
);

   localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
   localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

   emit_state_t            state_q, state_d;
   logic [M-1:0][N-1:0]    snap_q, snap_d;
   logic [I_WIDTH-1:0]     i_q, i_d, oi_q, oi_d, i_nx;
   logic [J_WIDTH-1:0]     j_q, j_d, oj_q, oj_d, j_nx;
   logic                   last_q, last_d;
   logic                   at_end;
`ifdef REGMAX_EMIT_COUNT_EN
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         oi_q    <= '0;
         oj_q    <= '0;
         last_q  <= 1'b0;
`ifdef REGMAX_EMIT_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         i_q     <= i_d;
         j_q     <= j_d;
         oi_q    <= oi_d;
         oj_q    <= oj_d;
         last_q  <= last_d;
`ifdef REGMAX_EMIT_COUNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // raster successor of the scan cursor, j innermost
   always_comb begin
      at_end = (i_q == I_LAST) && (j_q == J_LAST);
      if (j_q == J_LAST) begin
         j_nx = '0;
         i_nx = i_q + 1'b1;
      end else begin
         j_nx = j_q + 1'b1;
         i_nx = i_q;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      i_d     = i_q;
      j_d     = j_q;
      oi_d    = oi_q;
      oj_d    = oj_q;
      last_d  = last_q;
`ifdef REGMAX_EMIT_COUNT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = output_image;
               i_d     = '0;
               j_d     = '0;
`ifdef REGMAX_EMIT_COUNT_EN
               cnt_d   = '0;
`endif
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (snap_q[i_q][j_q]) begin
               snap_d[i_q][j_q] = 1'b0;
               oi_d    = i_q;
               oj_d    = j_q;
               last_d  = (snap_d == '0);
               state_d = S_EMIT;
            end else if (at_end) begin
               state_d = S_DONE;
            end else begin
               i_d = i_nx;
               j_d = j_nx;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
`ifdef REGMAX_EMIT_COUNT_EN
               cnt_d = cnt_q + 1'b1;
`endif
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  i_d     = i_nx;
                  j_d     = j_nx;
                  state_d = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q == S_SCAN) || (state_q == S_EMIT);
   assign out_valid = (state_q == S_EMIT);
   assign done      = (state_q == S_DONE);
   assign out_i     = oi_q;
   assign out_j     = oj_q;
   assign out_last  = last_q & out_valid;
`ifdef REGMAX_EMIT_COUNT_EN
   assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_regmax_coord_emitter.sv
// Randomized self-checking bench for regmax_coord_emitter (4x4 bitmap).
// Build with REGMAX_EMIT_COUNT_EN to also check match_count.
module tb_regmax_coord_emitter;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic [3:0][3:0]  output_image;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_i;
   logic [1:0]       out_j;
   logic             out_last;
   logic             done;
`ifdef REGMAX_EMIT_COUNT_EN
   logic [regmax_pkg::CNT_WIDTH-1:0] match_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   regmax_coord_emitter #(
      .M(4), .N(4), .I_WIDTH(2), .J_WIDTH(2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .output_image (output_image),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_i        (out_i),
      .out_j        (out_j),
      .out_last     (out_last),
      .done         (done)
`ifdef REGMAX_EMIT_COUNT_EN
      ,
      .match_count  (match_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: expected beats are the set bits in raster order. Frame
   // length follows from the last set cell, beat count and stall count.
   task automatic run_frame(input string nm, input logic [3:0][3:0] img,
                            input int stall_pct, input int first_stall,
                            input bit restart);
      int  q_i[$];
      int  q_j[$];
      int  last_idx = -1;
      int  k;
      int  stalls = 0;
      int  beats = 0;
      int  fs = first_stall;
      int  ei, ej;
      bit  got_done = 1'b0;
      bit  holding = 1'b0;
      bit  rdy;
      logic [1:0] hi, hj;
      logic       hl;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (img[i][j]) begin
               q_i.push_back(i);
               q_j.push_back(j);
               last_idx = i * 4 + j;
            end
      k = q_i.size();
      start = 1'b1;
      output_image = img;
      out_ready = 1'b0;
      tick();
      start = 1'b0;
      output_image = 16'($urandom);
      check({nm, " busy_after_start"}, busy, 1);
      for (int c = 0; c < 300 && !got_done; c++) begin
         start = 1'b0;
         if (out_valid) begin
            if (holding) begin
               check({nm, " hold_i"}, out_i, hi);
               check({nm, " hold_j"}, out_j, hj);
               check({nm, " hold_last"}, out_last, hl);
            end
            if (beats == 0 && fs > 0) begin
               rdy = 1'b0;
               fs--;
            end else begin
               rdy = ($urandom_range(99) >= stall_pct);
            end
            if (q_i.size() == 0) begin
               check({nm, " extra_beat"}, out_valid, 0);
               rdy = 1'b1;
            end else if (rdy) begin
               ei = q_i.pop_front();
               ej = q_j.pop_front();
               check({nm, " beat_i"}, out_i, ei);
               check({nm, " beat_j"}, out_j, ej);
               check({nm, " beat_last"}, out_last, q_i.size() == 0);
               beats++;
               holding = 1'b0;
            end else begin
               stalls++;
               holding = 1'b1;
               hi = out_i;
               hj = out_j;
               hl = out_last;
            end
            out_ready = rdy;
         end else begin
            holding = 1'b0;
            out_ready = 1'($urandom);
         end
         if (restart && c == 3) begin
            start = 1'b1;
            output_image = ~img;
         end
         if (done) begin
            got_done = 1'b1;
            check({nm, " busy_in_done"}, busy, 0);
            check({nm, " done_cycle"}, c,
                  (last_idx < 0 ? 16 : last_idx + 1) + k + stalls);
            check({nm, " beat_count"}, beats, k);
`ifdef REGMAX_EMIT_COUNT_EN
            check({nm, " match_count"}, match_count, k);
`endif
         end
         tick();
      end
      start = 1'b0;
      out_ready = 1'b0;
      check({nm, " done_seen"}, got_done, 1);
      check({nm, " done_one_cycle"}, done, 0);
      check({nm, " idle_busy"}, busy, 0);
`ifdef REGMAX_EMIT_COUNT_EN
      tick();
      check({nm, " count_held"}, match_count, k);
`endif
   endtask

   logic [3:0][3:0] img;

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      output_image = '0;
      tick();
      tick();
      check("rst busy", busy, 0);
      check("rst valid", out_valid, 0);
      check("rst i", out_i, 0);
      check("rst j", out_j, 0);
      check("rst last", out_last, 0);
      check("rst done", done, 0);
      reset_n = 1'b1;
      tick();

      img = '0;
      img[0][0] = 1'b1;
      img[1][2] = 1'b1;
      img[3][3] = 1'b1;
      run_frame("three", img, 0, 0, 1'b0);

      run_frame("zero", '0, 0, 0, 1'b0);

      img = '0;
      img[2][1] = 1'b1;
      img[3][0] = 1'b1;
      run_frame("stall5", img, 0, 5, 1'b0);

      img = '0;
      img[0][1] = 1'b1;
      img[2][2] = 1'b1;
      img[3][3] = 1'b1;
      run_frame("restart", img, 0, 0, 1'b1);

      run_frame("full", '1, 0, 0, 1'b0);
      run_frame("full_bp", '1, 50, 2, 1'b0);

      // reset while a beat is stalled
      img = '0;
      img[1][1] = 1'b1;
      img[2][3] = 1'b1;
      start = 1'b1;
      output_image = img;
      out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && !out_valid; c++) tick();
      check("pre_rst valid", out_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst valid", out_valid, 0);
      check("arst i", out_i, 0);
      check("arst j", out_j, 0);
      check("arst last", out_last, 0);
      check("arst busy", busy, 0);
      check("arst done", done, 0);
      tick();
      #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("post_rst no_done", done, 0);
      end
      out_ready = 1'b0;

      for (int f = 0; f < 25; f++) begin
         img = 16'($urandom & $urandom);
         run_frame($sformatf("rand%0d", f), img,
                   $urandom_range(0, 60), $urandom_range(0, 3), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regmax_coord_emitter.md
REGMAX_COORD_EMITTER -- requirements
Module: regmax_coord_emitter

Interface
REQ-001 SHALL have parameter M, default `CFG_M, meaning bitmap row count.
REQ-002 SHALL have parameter N, default `CFG_N, meaning bitmap column count.
REQ-003 SHALL have parameter I_WIDTH, default `CFG_I_WIDTH, meaning row-index width.
REQ-004 SHALL have parameter J_WIDTH, default `CFG_J_WIDTH, meaning column-index width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse: the regional-maximum bitmap is valid this cycle.
REQ-008 SHALL have port output_image  input  [M-1:0][N-1:0]  regional-maximum bitmap; bit [i][j]=1 marks a maximum at row i, column j.
REQ-009 SHALL have port busy  output  1  high from snapshot until done.
REQ-010 SHALL have port out_valid  output  1  coordinate beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port out_i  output  I_WIDTH  row of current maximum.
REQ-013 SHALL have port out_j  output  J_WIDTH  column of current maximum.
REQ-014 SHALL have port out_last  output  1  current beat is the frame's final maximum.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement FSM IDLE, SCAN, EMIT, DONE.
REQ-017 SHALL, in IDLE with start=1, snapshot output_image into an internal register, clear the scan index to (0,0), set busy, and enter SCAN next cycle.
REQ-018 SHALL ignore start outside IDLE; the snapshot SHALL be unaffected by later output_image changes.
REQ-019 SHALL, in SCAN, examine one cell per cycle in raster order (j inner 0..N-1, i outer 0..M-1).
REQ-020 SHALL, on a set cell, load out_i/out_j, clear that snapshot bit, and enter EMIT with out_valid=1 on the next cycle.
REQ-021 SHALL drive out_last=1 in EMIT iff the snapshot is all-zero after the clear.
REQ-022 SHALL hold out_valid, out_i, out_j, out_last stable in EMIT until out_valid&out_ready.
REQ-023 SHALL, on handshake, go to DONE if out_last=1, otherwise resume SCAN at the cell following the emitted one.
REQ-024 SHALL, in SCAN after examining cell (M-1,N-1) with no set bit, enter DONE; an all-zero frame emits no beats.
REQ-025 SHALL, in DONE, pulse done for exactly one cycle, clear busy, and return to IDLE; start in that cycle is ignored.
REQ-026 SHALL emit cells in strictly increasing raster order; a frame with K set bits yields exactly K beats.
REQ-027 SHALL handle out_ready held high: at most one beat per two cycles is required (SCAN+EMIT), no skip-ahead.

Reset
REQ-028 SHALL, on reset_n low, asynchronously force IDLE, snapshot=0, busy=0, out_valid=0, out_i=0, out_j=0, out_last=0, done=0 (and match_count=0 when present).
REQ-029 SHALL abandon a frame in progress on reset; no done pulse follows.

Configuration
REQ-030 SHALL, with macro REGMAX_EMIT_COUNT_EN defined, add output match_count (CNT_WIDTH), cleared on snapshot, incremented per handshake, held after done until next start.
REQ-031 SHALL, without REGMAX_EMIT_COUNT_EN, omit match_count port and counter; all other behaviour identical.

Structure
REQ-032 SHALL place state enum emit_state_t and localparam CNT_WIDTH=$clog2(M*N+1) in shared package regmax_pkg.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 SHALL cover M=N=4, bitmap bits (0,0),(1,2),(3,3) set, out_ready=1 -> beats (0,0),(1,2),(3,3), out_last only on (3,3), one done pulse.
REQ-035 SHALL cover all-zero bitmap -> zero out_valid cycles, done pulses after 16 SCAN cycles.
REQ-036 SHALL cover out_ready low 5 cycles on first beat (2,1) -> out_i=2, out_j=1 held stable, no loss.
REQ-037 SHALL cover start re-pulsed with different bitmap mid-frame -> ignored, original beats emitted.
REQ-038 SHALL cover reset_n low during EMIT -> outputs zero immediately, IDLE, no done.
REQ-039 SHALL cover REGMAX_EMIT_COUNT_EN with all 16 bits set -> 16 beats, match_count=16.
